// File: rtl/uart_tx.sv
// uart_tx: buffered 8N1 serial transmitter.
// Bytes are queued in a small FIFO and shifted out LSB first on o_bit_out.
// Back-to-back frames are sent with no idle gap while the FIFO holds data.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [7:0]                  i_data_in,
  input  logic                        i_data_valid,
  output logic                        o_data_ready,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_count,
  output logic                        o_busy,
  output logic                        o_bit_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  // serialiser state
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_idx;
  logic [7:0]    r_shift;
  logic          r_bit_out;

  // combinational next values
  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [2:0]    w_idx_nxt;
  logic [7:0]    w_shift_nxt;
  logic          w_bit_nxt;
  logic          w_push;
  logic          w_pop;
  logic          w_fifo_empty;
  logic          w_cnt_end;
  logic [7:0]    w_head;

  assign w_head       = r_mem[r_rd_ptr];
  assign w_fifo_empty = (r_count == '0);
  // Ready depends only on the registered count, so a pop in the same
  // cycle never admits a write into a full FIFO.
  assign o_data_ready = (r_count != (AW+1)'(FIFO_DEPTH));
  assign w_push       = i_data_valid & o_data_ready;
  assign w_cnt_end    = (r_cnt == CW'(CLKS_PER_BIT - 1));

  assign o_fifo_count = r_count;
  assign o_busy       = (r_state != IDLE) || !w_fifo_empty;
  assign o_bit_out    = r_bit_out;

  // FIFO data write; storage needs no reset since count gates every read
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data_in;
  end

  // FIFO pointers and occupancy; push and pop on one edge cancel in the count
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
    end
  end

  // serialiser state register; reset forces the line high immediately
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_shift   <= '0;
      r_bit_out <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_idx     <= w_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_out <= w_bit_nxt;
    end
  end

  // next-state and bit sequencing; each bit lasts exactly CLKS_PER_BIT cycles
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CW'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit_out;
    w_pop       = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        w_bit_nxt = 1'b1;
        if (!w_fifo_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_head;
          w_bit_nxt   = 1'b0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_cnt_end) begin
          w_cnt_nxt   = '0;
          w_bit_nxt   = r_shift[0];
          w_idx_nxt   = '0;
          w_state_nxt = DATA;
        end
      end
      DATA: begin
        if (w_cnt_end) begin
          w_cnt_nxt = '0;
          if (r_idx == 3'd7) begin
            w_bit_nxt   = 1'b1;
            w_state_nxt = STOP;
          end else begin
            w_shift_nxt = {1'b0, r_shift[7:1]};
            w_idx_nxt   = r_idx + 3'd1;
            w_bit_nxt   = r_shift[1];
          end
        end
      end
      STOP: begin
        if (w_cnt_end) begin
          w_cnt_nxt = '0;
          if (!w_fifo_empty) begin
            // chain straight into the next start bit
            w_pop       = 1'b1;
            w_shift_nxt = w_head;
            w_bit_nxt   = 1'b0;
            w_state_nxt = START;
          end else begin
            w_bit_nxt   = 1'b1;
            w_state_nxt = IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_bit_nxt   = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed bench for uart_tx (CLKS_PER_BIT=4 and 868 instances).
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] din_a, din_b;
  logic       vld_a, vld_b;
  logic       rdy_a, rdy_b;
  logic [4:0] cnt_a, cnt_b;
  logic       busy_a, busy_b;
  logic       tx_a, tx_b;

  int n_vec = 0;
  int n_err = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(16)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_data_in(din_a), .i_data_valid(vld_a),
    .o_data_ready(rdy_a), .o_fifo_count(cnt_a), .o_busy(busy_a), .o_bit_out(tx_a)
  );

  uart_tx #(.CLKS_PER_BIT(868), .FIFO_DEPTH(16)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_data_in(din_b), .i_data_valid(vld_b),
    .o_data_ready(rdy_b), .o_fifo_count(cnt_b), .o_busy(busy_b), .o_bit_out(tx_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance to 1ns after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // queue the per-cycle line level of one frame at 4 clocks per bit
  task automatic frame_push(input logic [7:0] b);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int k = 0; k < 10; k++)
      for (int j = 0; j < 4; j++) exp_q.push_back(f[k]);
  endtask

  task automatic stream_step(input string tag);
    logic e;
    e = exp_q.pop_front();
    chk(tag, {31'd0, tx_a}, {31'd0, e});
  endtask

  initial begin
    int c;
    logic [7:0] d;
    rst = 1'b1; vld_a = 1'b0; vld_b = 1'b0; din_a = 8'h00; din_b = 8'h00;
    #1;
    chk("rst_bit_out", {31'd0, tx_a}, 32'd1);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_count", {27'd0, cnt_a}, 32'd0);
    chk("rst_ready", {31'd0, rdy_a}, 32'd1);
    chk("rst_bit_out_b", {31'd0, tx_b}, 32'd1);
    tick(); tick();
    rst = 1'b0;

    // idle after reset with no writes
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_bit_out", {31'd0, tx_a}, 32'd1);
      chk("idle_busy", {31'd0, busy_a}, 32'd0);
      chk("idle_ready", {31'd0, rdy_a}, 32'd1);
    end

    // single byte 0xA5, checked every cycle
    frame_push(8'hA5);
    vld_a = 1'b1; din_a = 8'hA5;
    tick();
    vld_a = 1'b0; din_a = 8'hFF;
    chk("a5_count_after_push", {27'd0, cnt_a}, 32'd1);
    chk("a5_busy_after_push", {31'd0, busy_a}, 32'd1);
    chk("a5_line_before_pop", {31'd0, tx_a}, 32'd1);
    tick();
    chk("a5_count_after_pop", {27'd0, cnt_a}, 32'd0);
    for (int i = 0; i < 40; i++) begin
      stream_step("a5_line");
      chk("a5_busy", {31'd0, busy_a}, 32'd1);
      tick();
    end
    chk("a5_busy_end", {31'd0, busy_a}, 32'd0);
    chk("a5_line_end", {31'd0, tx_a}, 32'd1);
    tick();

    // three bytes on consecutive cycles, frames back to back
    frame_push(8'h11); frame_push(8'h22); frame_push(8'h33);
    vld_a = 1'b1; din_a = 8'h11;
    tick();
    din_a = 8'h22;
    tick();
    stream_step("b2b_line");
    din_a = 8'h33;
    tick();
    vld_a = 1'b0;
    chk("b2b_count", {27'd0, cnt_a}, 32'd2);
    for (int i = 1; i < 120; i++) begin
      stream_step("b2b_line");
      tick();
    end
    chk("b2b_busy_end", {31'd0, busy_a}, 32'd0);
    chk("b2b_line_end", {31'd0, tx_a}, 32'd1);
    tick();

    // hold valid for 20 cycles: 17 accepted, rest dropped
    for (int k = 0; k <= 16; k++) frame_push(8'h40 + 8'(k));
    vld_a = 1'b1; d = 8'h40; din_a = d;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k >= 1) stream_step("full_line");
      d = d + 8'd1; din_a = d;
    end
    vld_a = 1'b0;
    chk("full_count", {27'd0, cnt_a}, 32'd16);
    chk("full_ready", {31'd0, rdy_a}, 32'd0);
    while (exp_q.size() > 0) begin
      tick();
      stream_step("full_line");
    end
    tick();
    chk("full_busy_end", {31'd0, busy_a}, 32'd0);
    chk("full_line_end", {31'd0, tx_a}, 32'd1);
    chk("full_ready_end", {31'd0, rdy_a}, 32'd1);

    // reset during data bit 3 with 5 bytes queued
    vld_a = 1'b1; din_a = 8'h00;
    for (int k = 0; k < 6; k++) tick();
    vld_a = 1'b0;
    for (int k = 0; k < 13; k++) tick();
    chk("mid_count", {27'd0, cnt_a}, 32'd5);
    chk("mid_line_low", {31'd0, tx_a}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_rst_line", {31'd0, tx_a}, 32'd1);
    chk("mid_rst_busy", {31'd0, busy_a}, 32'd0);
    chk("mid_rst_count", {27'd0, cnt_a}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      chk("post_rst_line", {31'd0, tx_a}, 32'd1);
      chk("post_rst_busy", {31'd0, busy_a}, 32'd0);
    end

    // 868 clocks per bit: 0x00 gives 9 low bits then a high stop bit
    vld_b = 1'b1; din_b = 8'h00;
    tick();
    vld_b = 1'b0;
    chk("slow_line_pre", {31'd0, tx_b}, 32'd1);
    c = 0;
    tick();
    while (tx_b === 1'b0 && c < 10000) begin
      c++;
      tick();
    end
    chk("slow_low_cycles", c, 32'd7812);
    c = 0;
    while (tx_b === 1'b1 && busy_b === 1'b1 && c < 2000) begin
      c++;
      tick();
    end
    chk("slow_stop_cycles", c, 32'd868);
    chk("slow_busy_end", {31'd0, busy_b}, 32'd0);
    chk("slow_line_end", {31'd0, tx_b}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
